// File: rtl/spi_frame_sender_pkg.sv
// Shared panel constants and types for the HUB75 frame path.
// Used by spi_frame_sender, spi_tx_shifter and the HUB75 controller.
package spi_frame_sender_pkg;

  localparam int unsigned PANEL_WIDTH  = 64;
  localparam int unsigned PANEL_HEIGHT = 32;
  localparam int unsigned PIXEL_BITS   = 16;

  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned HALF_CNT_W = 8;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StLow,
    StHigh,
    StDone
  } state_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// 16-bit load/shift register with the spi_clk half-period timer and bit counter.
// Ports:
//   clk, n_reset        clock, asynchronous active-low reset
//   clear               synchronous clear of all state (frame abort)
//   load, load_data     capture a new pixel word, restart bit and half-period counts
//   tick_en             half-period timer runs (LOW or HIGH phase)
//   in_high             current phase is HIGH; a bit completes at the end of HIGH
//   msb, next_msb       shift[15] and the bit that becomes MSB after the next shift
//   half_done           last cycle of the current half period
//   bit_done, word_done end of a bit's HIGH phase / of bit 15's HIGH phase
module spi_tx_shifter
  import spi_frame_sender_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [PIXEL_BITS-1:0] load_data,
  input  logic                  tick_en,
  input  logic                  in_high,
  output logic                  msb,
  output logic                  next_msb,
  output logic                  half_done,
  output logic                  bit_done,
  output logic                  word_done
);

  localparam logic [HALF_CNT_W-1:0] LastHalf = HALF_CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0]  LastBit  = BIT_CNT_W'(PIXEL_BITS - 1);

  logic [PIXEL_BITS-1:0] shift_q;
  logic [HALF_CNT_W-1:0] half_cnt_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;

  assign half_done = tick_en && (half_cnt_q == LastHalf);
  assign bit_done  = half_done && in_high;
  assign word_done = bit_done && (bit_cnt_q == LastBit);
  assign msb       = shift_q[PIXEL_BITS-1];
  assign next_msb  = shift_q[PIXEL_BITS-2];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shift_q    <= '0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (clear) begin
      shift_q    <= '0;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (load) begin
      shift_q    <= load_data;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      if (tick_en) begin
        half_cnt_q <= half_done ? '0 : half_cnt_q + 1'b1;
      end
      // Last bit is not shifted out; the next load replaces the word.
      if (bit_done && !word_done) begin
        shift_q   <= {shift_q[PIXEL_BITS-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_frame_sender.sv
// Streams a frame from a synchronous pixel memory to the HUB75 controller over SPI.
// Ports:
//   clk, n_reset   clock, asynchronous active-low reset
//   start, abort   frame request (sampled in IDLE) / stop the frame in progress
//   busy, done     frame in progress / one-cycle end-of-frame pulse
//   pixel_addr     read address to the frame memory; pixel_data returns one clk later
//   spi_clk        serial clock, idles low; spi_mosi changes only while spi_clk is low
module spi_frame_sender
  import spi_frame_sender_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned PIXEL_COUNT = PANEL_WIDTH * PANEL_HEIGHT
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     pixel_addr,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  spi_clk,
  output logic                  spi_mosi
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PIXEL_COUNT - 1);

  state_e            state_q;
  logic              busy_q, done_q, spi_clk_q, spi_mosi_q;
  logic [ADDR_W-1:0] pixel_addr_q;

  logic sh_load, sh_tick, sh_high;
  logic sh_msb, sh_next_msb, half_done, bit_done, word_done;

  assign sh_load = (state_q == StLoad);
  assign sh_tick = (state_q == StLow) || (state_q == StHigh);
  assign sh_high = (state_q == StHigh);

  spi_tx_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .n_reset  (n_reset),
    .clear    (abort),
    .load     (sh_load),
    .load_data(pixel_data),
    .tick_en  (sh_tick),
    .in_high  (sh_high),
    .msb      (sh_msb),
    .next_msb (sh_next_msb),
    .half_done(half_done),
    .bit_done (bit_done),
    .word_done(word_done)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      spi_clk_q    <= 1'b0;
      spi_mosi_q   <= 1'b0;
      pixel_addr_q <= '0;
    end else if (abort) begin
      // Abort wins over everything, including a start in IDLE.
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spi_clk_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q      <= StFetch;
            busy_q       <= 1'b1;
            pixel_addr_q <= '0;
          end
        end
        StFetch: state_q <= StLoad;
        StLoad: begin
          // Shifter loads on this same edge, so take the MSB straight from memory.
          state_q    <= StLow;
          spi_mosi_q <= pixel_data[PIXEL_BITS-1];
        end
        StLow: begin
          spi_mosi_q <= sh_msb;
          if (half_done) begin
            state_q   <= StHigh;
            spi_clk_q <= 1'b1;
          end
        end
        StHigh: begin
          if (bit_done) begin
            spi_clk_q <= 1'b0;
            if (!word_done) begin
              state_q    <= StLow;
              spi_mosi_q <= sh_next_msb;
            end else if (pixel_addr_q < LastAddr) begin
              state_q      <= StFetch;
              pixel_addr_q <= pixel_addr_q + 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign spi_clk    = spi_clk_q;
  assign spi_mosi   = spi_mosi_q;
  assign pixel_addr = pixel_addr_q;

endmodule
